// File: rtl/serial_pair_transmitter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : serial_pair_transmitter_pkg                            |
// | Description : Shared types and constants for the serial pair         |
// |               transmitter: FSM state encoding and default width.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package serial_pair_transmitter_pkg;

  // Default operand width in bits
  localparam int c_DEFAULT_WIDTH = 8;

  // IDLE : no pair in flight
  // SHIFT: pair in flight, one bit emitted per cycle
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_pair_transmitter_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : serial_shift_reg                                       |
// | Description : Loadable 2*WIDTH shift register holding an A/B operand |
// |               pair. The bit-order select is applied at load time so  |
// |               the outgoing bit always sits in the top flop of each   |
// |               half; a and b are therefore direct flop outputs.       |
// | Ports       : clk, rst      - clock, async active-high reset         |
// |               load          - capture a_word/b_word (highest prio)   |
// |               clear         - zero the register                      |
// |               shift         - advance one bit                        |
// |               msb_first     - bit order applied at load              |
// |               a_word/b_word - parallel operands                      |
// |               a/b           - current serial bits                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module serial_shift_reg
  import serial_pair_transmitter_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             shift,
  input  logic             msb_first,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             a,
  output logic             b
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_rev;
  logic [WIDTH-1:0] w_b_rev;

  // Bit-reversed copies: LSB-first streams are loaded reversed so that
  // both orders shift out of the top bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign w_a_rev[i] = a_word[WIDTH-1-i];
    assign w_b_rev[i] = b_word[WIDTH-1-i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (load) begin
      r_a <= msb_first ? a_word : w_a_rev;
      r_b <= msb_first ? b_word : w_b_rev;
    end else if (clear) begin
      r_a <= '0;
      r_b <= '0;
    end else if (shift) begin
      r_a <= r_a << 1;
      r_b <= r_b << 1;
    end
  end

  assign a = r_a[WIDTH-1];
  assign b = r_b[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/serial_pair_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : serial_pair_transmitter                                |
// | Description : Accepts a parallel A/B operand pair and emits it       |
// |               bit-serially, one bit of each per cycle, with first/   |
// |               last framing. Back-to-back pairs stream without a gap. |
// | Ports       : clk, rst          - clock, async active-high reset     |
// |               in_valid/in_ready - parallel pair handshake            |
// |               a_word, b_word    - operands                           |
// |               msb_first         - bit order for the accepted pair    |
// |               bit_valid, a, b   - serial outputs (registered)        |
// |               first, last       - pair framing (registered)          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module serial_pair_transmitter
  import serial_pair_transmitter_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic             msb_first,
  output logic             bit_valid,
  output logic             a,
  output logic             b,
  output logic             first,
  output logic             last
);

  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  state_t             r_state;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic               w_at_last;
  logic               w_accept;
  logic               w_clear;
  logic               w_shift;

  assign w_count_nxt = r_count + c_ONE;
  assign w_at_last   = (r_state == SHIFT) && (r_count == c_LAST);

  // A new pair may be taken while idle or while the final bit is out,
  // which is what makes consecutive streams gap-free.
  assign in_ready = (r_state == IDLE) || w_at_last;
  assign w_accept = in_valid && in_ready;

  // Data is zeroed after the final bit so a/b read 0 whenever idle.
  assign w_clear  = w_at_last && !w_accept;
  assign w_shift  = (r_state == SHIFT) && !w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      bit_valid <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
    end else if (w_accept) begin
      r_state   <= SHIFT;
      r_count   <= '0;
      bit_valid <= 1'b1;
      first     <= 1'b1;
      last      <= (WIDTH == 1);
    end else if (r_state == SHIFT) begin
      if (w_at_last) begin
        r_state   <= IDLE;
        r_count   <= '0;
        bit_valid <= 1'b0;
        first     <= 1'b0;
        last      <= 1'b0;
      end else begin
        r_count   <= w_count_nxt;
        first     <= 1'b0;
        last      <= (w_count_nxt == c_LAST);
      end
    end
  end

  serial_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (w_accept),
    .clear     (w_clear),
    .shift     (w_shift),
    .msb_first (msb_first),
    .a_word    (a_word),
    .b_word    (b_word),
    .a         (a),
    .b         (b)
  );

endmodule
`default_nettype wire

// File: tb/tb_serial_pair_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_serial_pair_transmitter                             |
// | Description : Directed self-checking bench for the serial pair       |
// |               transmitter at WIDTH=4 and WIDTH=1.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_serial_pair_transmitter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_word;
  logic [W-1:0] b_word;
  logic         msb_first;
  logic         bit_valid;
  logic         a;
  logic         b;
  logic         first;
  logic         last;

  logic         in_valid1;
  logic         in_ready1;
  logic [0:0]   a_word1;
  logic [0:0]   b_word1;
  logic         msb_first1;
  logic         bit_valid1;
  logic         a1;
  logic         b1;
  logic         first1;
  logic         last1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_pair_transmitter #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .msb_first (msb_first),
    .bit_valid (bit_valid),
    .a         (a),
    .b         (b),
    .first     (first),
    .last      (last)
  );

  serial_pair_transmitter #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a_word    (a_word1),
    .b_word    (b_word1),
    .msb_first (msb_first1),
    .bit_valid (bit_valid1),
    .a         (a1),
    .b         (b1),
    .first     (first1),
    .last      (last1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".bit_valid"}, 32'(bit_valid), 32'd0);
    check_eq({tag, ".a"},         32'(a),         32'd0);
    check_eq({tag, ".b"},         32'(b),         32'd0);
    check_eq({tag, ".first"},     32'(first),     32'd0);
    check_eq({tag, ".last"},      32'(last),      32'd0);
    check_eq({tag, ".in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Offer one pair from an idle transmitter; returns just after the accept edge.
  task automatic offer(input logic [W-1:0] aw, input logic [W-1:0] bw, input logic msb);
    in_valid  = 1'b1;
    a_word    = aw;
    b_word    = bw;
    msb_first = msb;
    check_eq("offer.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  // Check one W-bit stream; exp_a/exp_b list bits in emission order, MSB = cycle 1.
  task automatic stream4(input string tag, input logic [W-1:0] exp_a, input logic [W-1:0] exp_b);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check_eq({tag, ".bit_valid"}, 32'(bit_valid), 32'd1);
      check_eq({tag, ".a"},         32'(a),         32'(exp_a[W-1-k]));
      check_eq({tag, ".b"},         32'(b),         32'(exp_b[W-1-k]));
      check_eq({tag, ".first"},     32'(first),     32'(k == 0));
      check_eq({tag, ".last"},      32'(last),      32'(k == W-1));
      check_eq({tag, ".in_ready"},  32'(in_ready),  32'(k == W-1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ea;
    logic [7:0] eb;
    logic [2:0] exp_lt;
    logic [2:0] exp_gt;
    logic [2:0] exp_eq;
    logic       m_lt;
    logic       m_gt;
    logic       m_done;
    int         p;

    rst        = 1'b1;
    in_valid   = 1'b0;
    a_word     = '0;
    b_word     = '0;
    msb_first  = 1'b0;
    in_valid1  = 1'b0;
    a_word1    = '0;
    b_word1    = '0;
    msb_first1 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle("reset");
    check_eq("reset.in_ready1",  32'(in_ready1),  32'd1);
    check_eq("reset.bit_valid1", 32'(bit_valid1), 32'd0);

    // First accept on the first edge after reset release, MSB first.
    // msb_first is flipped while in flight and must not disturb the stream.
    rst = 1'b0;
    offer(4'b1010, 4'b0110, 1'b1);
    msb_first = 1'b0;
    stream4("msb", 4'b1010, 4'b0110);
    @(negedge clk);
    check_idle("msb.after");

    // Same pair LSB first
    offer(4'b1010, 4'b0110, 1'b0);
    stream4("lsb", 4'b0101, 4'b0110);
    @(negedge clk);
    check_idle("lsb.after");

    // Back-to-back: (3,5) then (9,9), MSB first, in_valid held high
    in_valid  = 1'b1;
    a_word    = 4'd3;
    b_word    = 4'd5;
    msb_first = 1'b1;
    @(posedge clk);
    #1;
    a_word = 4'd9;
    b_word = 4'd9;
    ea = 8'b0011_1001;
    eb = 8'b0101_1001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("b2b.bit_valid", 32'(bit_valid), 32'd1);
      check_eq("b2b.a",         32'(a),         32'(ea[7-k]));
      check_eq("b2b.b",         32'(b),         32'(eb[7-k]));
      check_eq("b2b.first",     32'(first),     32'((k % 4) == 0));
      check_eq("b2b.last",      32'(last),      32'((k % 4) == 3));
      check_eq("b2b.in_ready",  32'(in_ready),  32'((k % 4) == 3));
      if (k == 3) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_idle("b2b.after");

    // Reset during the second bit discards the pair in flight
    offer(4'b1111, 4'b1111, 1'b1);
    @(negedge clk);
    check_eq("rstmid.bit0", 32'(bit_valid), 32'd1);
    @(negedge clk);
    check_eq("rstmid.bit1", 32'(bit_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_idle("rstmid.async");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle("rstmid.quiet");
    end
    offer(4'b1100, 4'b0011, 1'b0);
    stream4("rstmid.new", 4'b0011, 4'b1100);
    @(negedge clk);
    check_idle("rstmid.after");

    // End-to-end against an MSB-first serial comparator that restarts on first
    exp_lt    = 3'b001;
    exp_gt    = 3'b010;
    exp_eq    = 3'b100;
    m_lt      = 1'b0;
    m_gt      = 1'b0;
    m_done    = 1'b0;
    in_valid  = 1'b1;
    a_word    = 4'd5;
    b_word    = 4'd9;
    msb_first = 1'b1;
    @(posedge clk);
    #1;
    a_word = 4'd9;
    b_word = 4'd5;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_eq("cmp.bit_valid", 32'(bit_valid), 32'd1);
      if (first) begin
        m_lt   = 1'b0;
        m_gt   = 1'b0;
        m_done = 1'b0;
      end
      if (!m_done && (a != b)) begin
        m_lt   = b;
        m_gt   = a;
        m_done = 1'b1;
      end
      if ((k % 4) == 3) begin
        p = k / 4;
        check_eq("cmp.last",        32'(last),              32'd1);
        check_eq("cmp.a_less_b",    32'(m_lt),              32'(exp_lt[p]));
        check_eq("cmp.a_greater_b", 32'(m_gt),              32'(exp_gt[p]));
        check_eq("cmp.a_eq_b",      32'(!m_lt && !m_gt),    32'(exp_eq[p]));
      end
      if (k == 3) begin
        @(posedge clk);
        #1;
        a_word = 4'd7;
        b_word = 4'd7;
      end else if (k == 7) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_idle("cmp.after");

    // WIDTH=1: first and last together
    in_valid1  = 1'b1;
    a_word1    = 1'b1;
    b_word1    = 1'b0;
    msb_first1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check_eq("w1.bit_valid", 32'(bit_valid1), 32'd1);
    check_eq("w1.first",     32'(first1),     32'd1);
    check_eq("w1.last",      32'(last1),      32'd1);
    check_eq("w1.a",         32'(a1),         32'd1);
    check_eq("w1.b",         32'(b1),         32'd0);
    check_eq("w1.in_ready",  32'(in_ready1),  32'd1);
    @(negedge clk);
    check_eq("w1.after.bit_valid", 32'(bit_valid1), 32'd0);
    check_eq("w1.after.a",         32'(a1),         32'd0);
    check_eq("w1.after.first",     32'(first1),     32'd0);
    check_eq("w1.after.last",      32'(last1),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
